sap_controller: RTL and testbench

// - Controller-sequencer of the SAP CPU. Steps T-states, decodes the IR opcode nibble and drives every

---
 rtl/sap_pkg.sv | 61 ++++++
 rtl/sap_tstate_counter.sv | 55 +++++
 rtl/sap_controller.sv | 140 ++++++++++++++
 tb/tb_sap_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sap_pkg
//  Brief    : Shared SAP opcodes, T-state encoding and control-word bit map.
//  Revision : 1.0 - initial release
// ============================================================================
package sap_pkg;

    localparam int c_OPCODE_W = 4;
    localparam int c_STATE_W  = 3;

    localparam logic [c_OPCODE_W-1:0] c_OP_LDA = 4'b0000;
    localparam logic [c_OPCODE_W-1:0] c_OP_ADD = 4'b0001;
    localparam logic [c_OPCODE_W-1:0] c_OP_SUB = 4'b0010;
    localparam logic [c_OPCODE_W-1:0] c_OP_STA = 4'b0011;
    localparam logic [c_OPCODE_W-1:0] c_OP_JMP = 4'b0100;
    localparam logic [c_OPCODE_W-1:0] c_OP_OUT = 4'b1110;
    localparam logic [c_OPCODE_W-1:0] c_OP_HLT = 4'b1111;

    typedef enum logic [c_STATE_W-1:0] {
        ST_T1   = 3'd0,
        ST_T2   = 3'd1,
        ST_T3   = 3'd2,
        ST_T4   = 3'd3,
        ST_T5   = 3'd4,
        ST_T6   = 3'd5,
        ST_T7   = 3'd6,
        ST_HALT = 3'd7
    } tstate_e;

    // Control-word bit positions, also used by the datapath side.
    localparam int c_CW_PC_OUT  = 0;
    localparam int c_CW_PC_INC  = 1;
    localparam int c_CW_PC_LOAD = 2;
    localparam int c_CW_MAR_IN  = 3;
    localparam int c_CW_RAM_OUT = 4;
    localparam int c_CW_RAM_IN  = 5;
    localparam int c_CW_IR_IN   = 6;
    localparam int c_CW_IR_OUT  = 7;
    localparam int c_CW_A_IN    = 8;
    localparam int c_CW_A_OUT   = 9;
    localparam int c_CW_B_IN    = 10;
    localparam int c_CW_ALU_OUT = 11;
    localparam int c_CW_ALU_SUB = 12;
    localparam int c_CW_OUT_IN  = 13;
    localparam int c_CW_W       = 14;

    typedef logic [c_CW_W-1:0] ctrl_word_t;

    // Instructions that go on to address memory with the operand nibble.
    function automatic logic is_mem_op(input logic [c_OPCODE_W-1:0] op);
        return (op == c_OP_LDA) || (op == c_OP_ADD) ||
               (op == c_OP_SUB) || (op == c_OP_STA);
    endfunction

    function automatic logic is_alu_op(input logic [c_OPCODE_W-1:0] op);
        return (op == c_OP_ADD) || (op == c_OP_SUB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sap_tstate_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sap_tstate_counter
//  Brief    : T-state register with run gating and per-opcode early return.
//  Revision : 1.0 - initial release
// ============================================================================
module sap_tstate_counter
    import sap_pkg::*;
#(
    parameter int OPCODE_W = c_OPCODE_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    output tstate_e             tstate
);

    tstate_e r_state;
    tstate_e w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_T1:   w_next = run ? ST_T2 : ST_T1;
            ST_T2:   w_next = ST_T3;
            ST_T3:   w_next = ST_T4;
            ST_T4: begin
                if (opcode == c_OP_HLT)
                    w_next = ST_HALT;
                else if (is_mem_op(opcode))
                    w_next = ST_T5;
                else
                    w_next = ST_T1;
            end
            // STA finishes its write in T5; loads need T6 to catch RAM data.
            ST_T5:   w_next = (is_mem_op(opcode) && (opcode != c_OP_STA)) ? ST_T6 : ST_T1;
            ST_T6:   w_next = is_alu_op(opcode) ? ST_T7 : ST_T1;
            ST_T7:   w_next = ST_T1;
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_T1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= ST_T1;
        else
            r_state <= w_next;
    end

    assign tstate = r_state;

endmodule
`default_nettype wire

// File: rtl/sap_controller.sv
`default_nettype none
// ============================================================================
//  Module   : sap_controller
//  Brief    : SAP controller-sequencer; decodes T-state and opcode into the
//             bus load/enable control lines.
//  Revision : 1.0 - initial release
// ============================================================================
module sap_controller
    import sap_pkg::*;
#(
    parameter int OPCODE_W = c_OPCODE_W,
    parameter int STATE_W  = c_STATE_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                pc_out,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                mar_in,
    output logic                ram_out,
    output logic                ram_in,
    output logic                ir_in,
    output logic                ir_out,
    output logic                a_in,
    output logic                a_out,
    output logic                b_in,
    output logic                alu_out,
    output logic                alu_sub,
    output logic                out_in,
    output logic                halted,
    output logic [STATE_W-1:0]  tstate
);

    tstate_e    w_state;
    ctrl_word_t w_decode;
    ctrl_word_t w_cw;

    sap_tstate_counter #(
        .OPCODE_W (OPCODE_W)
    ) u_tstate_counter (
        .clock  (clock),
        .reset  (reset),
        .run    (run),
        .opcode (opcode),
        .tstate (w_state)
    );

    // Cycles after a ram_out (T3, T6) leave every other bus driver off so
    // the registered RAM data owns the bus.
    always_comb begin
        w_decode = '0;
        case (w_state)
            ST_T1: begin
                if (run) begin
                    w_decode[c_CW_PC_OUT] = 1'b1;
                    w_decode[c_CW_MAR_IN] = 1'b1;
                end
            end
            ST_T2: begin
                w_decode[c_CW_RAM_OUT] = 1'b1;
                w_decode[c_CW_PC_INC]  = 1'b1;
            end
            ST_T3: begin
                w_decode[c_CW_IR_IN] = 1'b1;
            end
            ST_T4: begin
                case (opcode)
                    c_OP_LDA, c_OP_ADD, c_OP_SUB, c_OP_STA: begin
                        w_decode[c_CW_IR_OUT] = 1'b1;
                        w_decode[c_CW_MAR_IN] = 1'b1;
                    end
                    c_OP_JMP: begin
                        w_decode[c_CW_IR_OUT]  = 1'b1;
                        w_decode[c_CW_PC_LOAD] = 1'b1;
                    end
                    c_OP_OUT: begin
                        w_decode[c_CW_A_OUT]  = 1'b1;
                        w_decode[c_CW_OUT_IN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (opcode)
                    c_OP_LDA, c_OP_ADD, c_OP_SUB: begin
                        w_decode[c_CW_RAM_OUT] = 1'b1;
                    end
                    c_OP_STA: begin
                        w_decode[c_CW_A_OUT]  = 1'b1;
                        w_decode[c_CW_RAM_IN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (opcode)
                    c_OP_LDA: w_decode[c_CW_A_IN] = 1'b1;
                    c_OP_ADD: w_decode[c_CW_B_IN] = 1'b1;
                    c_OP_SUB: begin
                        w_decode[c_CW_B_IN]    = 1'b1;
                        w_decode[c_CW_ALU_SUB] = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                if (is_alu_op(opcode)) begin
                    w_decode[c_CW_ALU_OUT] = 1'b1;
                    w_decode[c_CW_A_IN]    = 1'b1;
                    w_decode[c_CW_ALU_SUB] = (opcode == c_OP_SUB);
                end
            end
            default: ;
        endcase
    end

    // Reset silences every line at once so no write lands mid-abandon.
    assign w_cw   = reset ? '0 : w_decode;
    assign halted = (w_state == ST_HALT) && !reset;
    assign tstate = w_state;

    assign pc_out  = w_cw[c_CW_PC_OUT];
    assign pc_inc  = w_cw[c_CW_PC_INC];
    assign pc_load = w_cw[c_CW_PC_LOAD];
    assign mar_in  = w_cw[c_CW_MAR_IN];
    assign ram_out = w_cw[c_CW_RAM_OUT];
    assign ram_in  = w_cw[c_CW_RAM_IN];
    assign ir_in   = w_cw[c_CW_IR_IN];
    assign ir_out  = w_cw[c_CW_IR_OUT];
    assign a_in    = w_cw[c_CW_A_IN];
    assign a_out   = w_cw[c_CW_A_OUT];
    assign b_in    = w_cw[c_CW_B_IN];
    assign alu_out = w_cw[c_CW_ALU_OUT];
    assign alu_sub = w_cw[c_CW_ALU_SUB];
    assign out_in  = w_cw[c_CW_OUT_IN];

endmodule
`default_nettype wire

// File: tb/tb_sap_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sap_controller
//  Brief    : Directed bench: controller driving a small SAP datapath model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sap_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       run   = 1'b0;
    logic [3:0] opcode;
    logic       pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out;
    logic       a_in, a_out, b_in, alu_out, alu_sub, out_in, halted;
    logic [2:0] tstate;

    sap_controller #(.OPCODE_W(4), .STATE_W(3)) dut (
        .clock(clock), .reset(reset), .run(run), .opcode(opcode),
        .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_in(mar_in),
        .ram_out(ram_out), .ram_in(ram_in), .ir_in(ir_in), .ir_out(ir_out),
        .a_in(a_in), .a_out(a_out), .b_in(b_in), .alu_out(alu_out),
        .alu_sub(alu_sub), .out_in(out_in), .halted(halted), .tstate(tstate)
    );

    always #5 clock = ~clock;

    // Bench-side bit order, independent of the design's packing.
    localparam logic [13:0] K_PC_OUT = 14'h2000;
    localparam logic [13:0] K_MAR_IN = 14'h0400;
    localparam logic [13:0] K_B_IN   = 14'h0008;
    logic [13:0] ctrl;
    assign ctrl = {pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in,
                   ir_out, a_in, a_out, b_in, alu_out, alu_sub, out_in};

    // Datapath model: PC, MAR, registered-read RAM, IR, A, B, OUT.
    logic [7:0] mem [16];
    logic [3:0] pc = 4'h0, mar = 4'h0;
    logic [7:0] ir = 8'h00, a = 8'h00, b = 8'h00, outr = 8'h00, ram_q = 8'h00;
    logic       ram_vld = 1'b0;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = 4'h0;
    logic [7:0] prog_data = 8'h00;
    logic [7:0] bus, alu;
    int         ndrv;
    int         conflicts = 0;

    assign opcode = ir[7:4];

    always_comb begin
        alu  = alu_sub ? (a - b) : (a + b);
        bus  = 8'h00;
        ndrv = 0;
        if (pc_out)  begin bus = {4'h0, pc};      ndrv = ndrv + 1; end
        if (ram_vld) begin bus = ram_q;           ndrv = ndrv + 1; end
        if (ir_out)  begin bus = {4'h0, ir[3:0]}; ndrv = ndrv + 1; end
        if (a_out)   begin bus = a;               ndrv = ndrv + 1; end
        if (alu_out) begin bus = alu;             ndrv = ndrv + 1; end
    end

    always @(posedge clock) begin
        if (prog_we) mem[prog_addr] <= prog_data;
        if (ram_in)  mem[mar] <= bus;
        if (ram_out) ram_q <= mem[mar];
        ram_vld <= ram_out && !reset;
        if (reset)        pc <= 4'h0;
        else if (pc_load) pc <= bus[3:0];
        else if (pc_inc)  pc <= pc + 4'h1;
        if (mar_in) mar  <= bus[3:0];
        if (ir_in)  ir   <= bus;
        if (a_in)   a    <= bus;
        if (b_in)   b    <= bus;
        if (out_in) outr <= bus;
        if (!reset && ndrv > 1) conflicts <= conflicts + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic poke(input logic [3:0] addr, input logic [7:0] data);
        prog_addr = addr; prog_data = data; prog_we = 1'b1;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic clear_mem();
        reset = 1'b1; run = 1'b0;
        for (int i = 0; i < 16; i++) poke(4'(i), 8'h00);
    endtask

    // Run statistics gathered by run_prog.
    int n_cyc;
    int t1q[$];
    int sub_t6, sub_t7, sub_other, ramin_t5, ramin_other, pcl_t4, pcl_other, nop_ctrl;

    task automatic run_prog(input int max_cyc, input bit stop_on_halt);
        n_cyc = 0; t1q.delete();
        sub_t6 = 0; sub_t7 = 0; sub_other = 0; ramin_t5 = 0; ramin_other = 0;
        pcl_t4 = 0; pcl_other = 0; nop_ctrl = 0;
        reset = 1'b0; run = 1'b1; #1;
        while (n_cyc < max_cyc && !(stop_on_halt && halted)) begin
            if (tstate == 3'd0) t1q.push_back(n_cyc);
            if (alu_sub) begin
                if (tstate == 3'd5) sub_t6++;
                else if (tstate == 3'd6) sub_t7++;
                else sub_other++;
            end
            if (ram_in)  begin if (tstate == 3'd4) ramin_t5++; else ramin_other++; end
            if (pc_load) begin if (tstate == 3'd3) pcl_t4++;   else pcl_other++;   end
            if (tstate == 3'd3 && opcode == 4'b0101 && ctrl != 14'h0) nop_ctrl++;
            tick();
            n_cyc++;
        end
    endtask

    function automatic int gap(input int k);
        return (t1q.size() > k) ? (t1q[k] - t1q[k-1]) : -1;
    endfunction

    int found;

    initial begin
        // Reset state, including run=1 while reset is held.
        tick(); tick();
        check("reset_tstate", 32'(tstate), 32'd0);
        check("reset_ctrl", 32'(ctrl), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        run = 1'b1; #1;
        check("reset_run_ctrl", 32'(ctrl), 32'd0);

        // Program: LDA 9; ADD A; OUT; HLT.
        clear_mem();
        poke(4'h0, 8'h09); poke(4'h1, 8'h1A); poke(4'h2, 8'hE0); poke(4'h3, 8'hF0);
        poke(4'h9, 8'h05); poke(4'hA, 8'h03);

        reset = 1'b0; run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_tstate", 32'(tstate), 32'd0);
            check("idle_ctrl", 32'(ctrl), 32'd0);
        end
        run = 1'b1; #1;
        check("run_start_ctrl", 32'(ctrl), 32'(K_PC_OUT | K_MAR_IN));

        run_prog(100, 1'b1);
        check("prog1_halted", 32'(halted), 32'd1);
        check("prog1_cycles", 32'(n_cyc), 32'd21);   // 6 + 7 + 4 + 4
        check("prog1_out", 32'(outr), 32'h08);
        check("prog1_tstate", 32'(tstate), 32'd7);
        run = 1'b0; tick(); tick(); run = 1'b1; tick();
        check("halt_stays", 32'(tstate), 32'd7);
        check("halt_ctrl", 32'(ctrl), 32'd0);

        // Reset held 3 cycles at ADD T6; mem[A] changed so any b_in would show.
        reset = 1'b1; run = 1'b0;
        poke(4'hA, 8'h77);
        reset = 1'b0; run = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (tstate == 3'd5 && opcode == 4'h1) found = 1;
            else tick();
        end
        check("add_t6_reached", 32'(found), 32'd1);
        check("add_t6_ctrl", 32'(ctrl), 32'(K_B_IN));
        reset = 1'b1; #1;
        check("midreset_ctrl", 32'(ctrl), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midreset_tstate", 32'(tstate), 32'd0);
            check("midreset_ctrl_hold", 32'(ctrl), 32'd0);
        end
        reset = 1'b0; run = 1'b0; tick();
        check("postreset_tstate", 32'(tstate), 32'd0);
        check("midreset_b", 32'(b), 32'h03);
        check("midreset_a", 32'(a), 32'h05);

        // Program: LDA 9; SUB A; OUT; HLT with 5 - 7.
        clear_mem();
        poke(4'h0, 8'h09); poke(4'h1, 8'h2A); poke(4'h2, 8'hE0); poke(4'h3, 8'hF0);
        poke(4'h9, 8'h05); poke(4'hA, 8'h07);
        run_prog(100, 1'b1);
        check("sub_halted", 32'(halted), 32'd1);
        check("sub_out", 32'(outr), 32'hFE);
        check("sub_lda_len", 32'(gap(1)), 32'd6);
        check("sub_len", 32'(gap(2)), 32'd7);
        check("sub_t6", 32'(sub_t6), 32'd1);
        check("sub_t7", 32'(sub_t7), 32'd1);
        check("sub_other", 32'(sub_other), 32'd0);

        // Program: LDA 8; STA F; ADD 9; LDA F; OUT; HLT.
        clear_mem();
        poke(4'h0, 8'h08); poke(4'h1, 8'h3F); poke(4'h2, 8'h19); poke(4'h3, 8'h0F);
        poke(4'h4, 8'hE0); poke(4'h5, 8'hF0); poke(4'h8, 8'h3C); poke(4'h9, 8'h05);
        run_prog(100, 1'b1);
        check("sta_halted", 32'(halted), 32'd1);
        check("sta_mem", 32'(mem[15]), 32'h3C);
        check("sta_reload_out", 32'(outr), 32'h3C);
        check("sta_len", 32'(gap(2)), 32'd5);
        check("sta_ramin_t5", 32'(ramin_t5), 32'd1);
        check("sta_ramin_other", 32'(ramin_other), 32'd0);

        // Program: NOP(0101); JMP 0 looping for 24 cycles.
        clear_mem();
        poke(4'h0, 8'h50); poke(4'h1, 8'h40);
        run_prog(24, 1'b0);
        check("loop_nop_len", 32'(gap(1)), 32'd4);
        check("loop_jmp_len", 32'(gap(2)), 32'd4);
        check("loop_pcl_t4", 32'(pcl_t4), 32'd3);
        check("loop_pcl_other", 32'(pcl_other), 32'd0);
        check("loop_nop_ctrl", 32'(nop_ctrl), 32'd0);
        check("loop_pc", 32'(pc), 32'd0);
        check("loop_not_halted", 32'(halted), 32'd0);

        check("bus_conflicts", 32'(conflicts), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
